bcd_count_core: RTL and testbench

- Upstream stage of the 4-digit seven-segment display controller.
- Debounces three pushbuttons (run/pause, direction, clear) and generates a 1 Hz count enable from the 50 MHz board clock.
- Maintains a two-digit packed-BCD counter 00-99 (up or down, wrapping).
- Drives the display controller's 8-bit count input: [7:4] tens, [3:0] ones.

---
 rtl/bcd_count_core.sv | 160 ++++++++++++++++
 tb/tb_bcd_count_core.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_core.sv
`timescale 1ns/1ps
// bcd_count_core: debounces run/dir/clear buttons, divides the board clock into
// a count step enable, and keeps a wrapping two-digit packed-BCD up/down counter.
module bcd_count_core #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic       btn_clr,
  output logic [7:0] count,
  output logic       running,
  output logic       dir_down,
  output logic       tick
);

  localparam int unsigned NB = 3;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DB_CYCLES - 1);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] w_press;
  logic          w_run_p;
  logic          w_dir_p;
  logic          w_clr_p;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          w_step;

  logic [7:0]    r_count;
  logic [7:0]    w_count_step;
  logic [7:0]    w_count_next;
  logic [3:0]    w_ones;
  logic [3:0]    w_tens;
  logic          r_tick;
  logic          r_running;
  logic          r_dir;

  // Bit order: 0 = run, 1 = dir, 2 = clear.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {btn_clr, btn_dir, btn_run};
      r_sync2 <= r_sync1;
    end
  end

  // Press pulse fires in the cycle the debounced level is about to rise.
  for (genvar gi = 0; gi < NB; gi++) begin : g_db
    logic [DW-1:0] r_cnt;
    logic          r_lvl;

    always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync2[gi] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_MAX) begin
        r_lvl <= r_sync2[gi];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end

    assign w_press[gi] = r_sync2[gi] & ~r_lvl & (r_cnt == DB_MAX);
  end

  assign w_run_p = w_press[0];
  assign w_dir_p = w_press[1];
  assign w_clr_p = w_press[2];

  // Next state and prescaler; clear overrides run and suppresses any step.
  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_step       = 1'b0;
    if (w_clr_p) begin
      w_state_next = ST_STOP;
      w_presc_next = '0;
    end else begin
      if (r_state == ST_RUN) begin
        if (r_presc == PRESC_MAX) begin
          w_presc_next = '0;
          w_step       = 1'b1;
        end else begin
          w_presc_next = r_presc + PW'(1);
        end
      end
      if (w_run_p) begin
        w_state_next = (r_state == ST_RUN) ? ST_STOP : ST_RUN;
      end
    end
  end

  assign w_ones = r_count[3:0];
  assign w_tens = r_count[7:4];

  // One BCD step in the current direction, wrapping 99<->00.
  always_comb begin
    w_count_step = r_count;
    if (!r_dir) begin
      if (w_ones == 4'd9) begin
        w_count_step[3:0] = 4'd0;
        w_count_step[7:4] = (w_tens == 4'd9) ? 4'd0 : w_tens + 4'd1;
      end else begin
        w_count_step[3:0] = w_ones + 4'd1;
      end
    end else begin
      if (w_ones == 4'd0) begin
        w_count_step[3:0] = 4'd9;
        w_count_step[7:4] = (w_tens == 4'd0) ? 4'd9 : w_tens - 4'd1;
      end else begin
        w_count_step[3:0] = w_ones - 4'd1;
      end
    end
  end

  assign w_count_next = w_clr_p ? 8'h00 : (w_step ? w_count_step : r_count);

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STOP;
      r_presc   <= '0;
      r_count   <= 8'h00;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_dir     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_presc   <= w_presc_next;
      r_count   <= w_count_next;
      r_tick    <= w_step;
      r_running <= (w_state_next == ST_RUN);
      r_dir     <= r_dir ^ w_dir_p;
    end
  end

  assign count    = r_count;
  assign running  = r_running;
  assign dir_down = r_dir;
  assign tick     = r_tick;

endmodule

// File: tb/tb_bcd_count_core.sv
`timescale 1ns/1ps
// tb_bcd_count_core: randomized and directed button stimulus against an
// integer-arithmetic model; a monitor checks every tick's count and timing.
module tb_bcd_count_core;

  localparam int TD  = 4;
  localparam int DB  = 3;
  localparam int H   = DB + 3;
  localparam int LAT = DB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_run, b_dir, b_clr;
  logic [7:0] count;
  logic       running, dir_down, tick;

  bcd_count_core #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk_50MHz (clk),
    .reset     (rst),
    .btn_run   (b_run),
    .btn_dir   (b_dir),
    .btn_clr   (b_clr),
    .count     (count),
    .running   (running),
    .dir_down  (dir_down),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t, ts;
  bit   ev_run, ev_dir, ev_clr;
  bit   rr, rd, rc;
  int   m_count, m_phase;
  bit   m_run, m_dir;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model in "press time": the cycle the bench raises a button.
  // The DUT acts on that press LAT cycles later.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_count = 0; m_phase = 0; m_run = 0; m_dir = 0;
      sb_q.delete();
    end else begin
      if (ev_clr) begin
        m_count = 0; m_phase = 0; m_run = 0;
      end else begin
        if (m_run) begin
          m_phase = m_phase + 1;
          if (m_phase == TD) begin
            m_phase = 0;
            m_count = m_dir ? (m_count + 99) % 100 : (m_count + 1) % 100;
            sb_q.push_back('{cnt: to_bcd(m_count), due: cyc + LAT});
          end
        end
        if (ev_run) m_run = !m_run;
      end
      if (ev_dir) m_dir = !m_dir;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tick === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_tick: tick with count %0h at cycle %0d, expected no tick", count, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("tick_count", 32'(count), 32'(mon_e.cnt));
          check("tick_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
        mon_e = sb_q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL missed_tick: no tick by cycle %0d, expected count %0h at cycle %0d", cyc, mon_e.cnt, mon_e.due);
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic push_btn(input bit r, input bit d, input bit c);
    if (r) b_run = 1'b1;
    if (d) b_dir = 1'b1;
    if (c) b_clr = 1'b1;
    ev_run = r; ev_dir = d; ev_clr = c;
    clk_n(1);
    ev_run = 1'b0; ev_dir = 1'b0; ev_clr = 1'b0;
  endtask

  task automatic rel_btn(input bit r, input bit d, input bit c);
    if (r) b_run = 1'b0;
    if (d) b_dir = 1'b0;
    if (c) b_clr = 1'b0;
  endtask

  task automatic press(input bit r, input bit d, input bit c, input int hold);
    push_btn(r, d, c);
    clk_n(hold - 1);
    rel_btn(r, d, c);
    clk_n(H);
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  initial begin
    #2_000_000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: still running at %0t, expected completion", $time);
    summary();
    $finish;
  end

  initial begin
    rst = 1'b1; b_run = 1'b0; b_dir = 1'b0; b_clr = 1'b0;
    ev_run = 1'b0; ev_dir = 1'b0; ev_clr = 1'b0;
    clk_n(3);
    check("rst_count", 32'(count), 32'h00);
    check("rst_running", 32'(running), 32'd0);
    check("rst_dir", 32'(dir_down), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    clk_n(100);
    check("idle_count", 32'(count), 32'h00);
    check("idle_running", 32'(running), 32'd0);

    // Run 100 steps (through 98, 99, 00), reverse, then pause mid-period.
    t = cyc + 1;
    push_btn(1, 0, 0);
    at_cyc(t + DB);
    check("run_latency_early", 32'(running), 32'd0);
    clk_n(1);
    check("run_latency", 32'(running), 32'd1);
    at_cyc(t + 9);
    rel_btn(1, 0, 0);
    at_cyc(t + 10 * TD + LAT);
    check("count_10", 32'(count), 32'h10);
    at_cyc(t + 100 * TD);
    push_btn(0, 1, 0);
    at_cyc(t + 409);
    push_btn(1, 0, 0);
    at_cyc(t + 416);
    rel_btn(1, 1, 0);
    at_cyc(t + 440);
    check("pause_count_a", 32'(count), 32'h98);
    check("pause_running", 32'(running), 32'd0);
    check("pause_dir", 32'(dir_down), 32'd1);
    at_cyc(t + 465);
    check("pause_count_b", 32'(count), 32'h98);
    ts = cyc + 1;
    push_btn(1, 0, 0);
    at_cyc(ts + DB + 3);
    rel_btn(1, 0, 0);
    at_cyc(ts + 2 + 3 * TD);
    press(1, 0, 0, H);

    // Bouncing run button then a short clear glitch while running.
    for (int i = 0; i < 20; i++) begin
      b_run = (i % 2 == 0);
      clk_n(1);
    end
    check("bounce_no_early_run", 32'(running), 32'd0);
    t = cyc + 1;
    push_btn(1, 0, 0);
    at_cyc(t + LAT);
    check("bounce_single_run", 32'(running), 32'd1);
    at_cyc(t + 12);
    rel_btn(1, 0, 0);
    clk_n(4);
    b_clr = 1'b1;
    clk_n(2);
    b_clr = 1'b0;
    clk_n(20);
    check("glitch_no_clear", 32'(running), 32'd1);
    press(1, 0, 0, H);

    // Clear keeps direction; then reset mid-run at 37.
    press(0, 0, 1, H);
    check("clear_count", 32'(count), 32'h00);
    check("clear_keeps_dir", 32'(dir_down), 32'd1);
    press(0, 1, 0, H);
    check("dir_up", 32'(dir_down), 32'd0);
    t = cyc + 1;
    push_btn(1, 0, 0);
    at_cyc(t + DB + 3);
    rel_btn(1, 0, 0);
    at_cyc(t + 37 * TD + LAT + 1);
    check("pre_reset_count", 32'(count), 32'h37);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'h00);
    check("async_rst_running", 32'(running), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    clk_n(2);
    rst = 1'b0;
    clk_n(100);
    check("post_reset_count", 32'(count), 32'h00);

    // Clear and run together at 45, exactly on a step.
    t = cyc + 1;
    push_btn(1, 0, 0);
    at_cyc(t + DB + 3);
    rel_btn(1, 0, 0);
    at_cyc(t + 46 * TD - 1);
    push_btn(1, 0, 1);
    at_cyc(t + 46 * TD + LAT - 1);
    check("simul_pre_count", 32'(count), 32'h45);
    clk_n(1);
    check("simul_count", 32'(count), 32'h00);
    check("simul_running", 32'(running), 32'd0);
    check("simul_tick", 32'(tick), 32'd0);
    rel_btn(1, 0, 1);
    clk_n(H);

    // Direction press coinciding with the 10->11 step.
    t = cyc + 1;
    push_btn(1, 0, 0);
    at_cyc(t + DB + 3);
    rel_btn(1, 0, 0);
    at_cyc(t + 11 * TD - 1);
    push_btn(0, 1, 0);
    at_cyc(t + 11 * TD + LAT);
    check("dir_coincide_count", 32'(count), 32'h11);
    check("dir_coincide_dir", 32'(dir_down), 32'd1);
    rel_btn(0, 1, 0);
    at_cyc(t + 12 * TD + LAT);
    check("dir_after_count", 32'(count), 32'h10);
    press(1, 0, 0, H);

    // Random button traffic.
    for (int k = 0; k < 40; k++) begin
      clk_n(int'($urandom_range(0, 12)));
      rc = ($urandom_range(0, 4) == 0);
      rr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!rr && !rd && !rc) rr = 1'b1;
      press(rr, rd, rc, int'($urandom_range(H, H + 8)));
    end
    if (m_run) press(1, 0, 0, H);
    clk_n(LAT + 4);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("final_count", 32'(count), 32'(to_bcd(m_count)));
    check("final_running", 32'(running), 32'(m_run));
    check("final_dir", 32'(dir_down), 32'(m_dir));

    summary();
    $finish;
  end

endmodule
